master_port: RTL
================

Name: master_port

Overview:
Initiator end of the serial system bus. Accepts one parallel read/write request from a local master device and serializes the address on mwdata, followed by write data for writes. For reads, it deserializes the slave's srdata/svalid response into a parallel word. It sits between a bus master and the serial bus/slave_port, and adds a read-response timeout so a missing slave cannot hang the master.

Parameters:
ADDR_WIDTH, 12, address bits sent per transaction
DATA_WIDTH, 8, data bits per word
TIMEOUT, 64, max consecutive cycles without svalid during a read response before abort (>=1)

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  synchronous reset, active-high (asserted = 1); port name kept for bus-wide consistency
dvalid  in  1  device request valid
dmode  in  1  1 = write, 0 = read
daddr  in  ADDR_WIDTH  request address
dwdata  in  DATA_WIDTH  write data
dready  out  1  port idle; request accepted when dvalid && dready
drdata  out  DATA_WIDTH  last successful read data
drvalid  out  1  1-cycle pulse, drdata freshly updated
dack  out  1  1-cycle pulse, transaction finished (write, read or timeout)
derr  out  1  valid with dack; 1 = read timed out
mwdata  out  1  serial address/write data to slave
mmode  out  1  transaction mode to slave, valid while mvalid = 1
mvalid  out  1  mwdata/mmode valid
srdata  in  1  serial read data from slave
svalid  in  1  srdata valid

Behaviour:
- Reset (rstn = 1 at edge): state IDLE. mvalid, mwdata, mmode, drvalid, dack, derr = 0; drdata = 0; dready = 1. Reset mid-transaction aborts it: mvalid = 0 from the next cycle, no dack.
- All outputs are registered except dready = (state == IDLE).
- Bit order: LSB first for address and data.
- States: IDLE, ADDR, WDATA, RWAIT, RDATA, DONE.
- IDLE: on dvalid latch dmode, daddr, dwdata -> ADDR. dvalid is ignored in all other states.
- ADDR: ADDR_WIDTH cycles, mvalid = 1, mmode = latched mode, mwdata = addr[i] in the i-th cycle. Then -> WDATA if write, -> RWAIT if read.
- WDATA: DATA_WIDTH cycles, mvalid = 1, mwdata = data[i]. Then -> DONE.
- RWAIT: mvalid = 0. Each svalid = 1 cycle captures srdata as bit 0 -> RDATA.
- RDATA: each svalid = 1 cycle shifts srdata into the next bit. Gaps (svalid = 0) are tolerated. When the DATA_WIDTH-th bit is captured -> DONE with success.
- Timeout: counter clears on entry to RWAIT and on every svalid = 1. It increments on each svalid = 0 cycle in RWAIT/RDATA. When it reaches TIMEOUT -> DONE with error; partial data is discarded.
- DONE, one cycle: dack = 1. Successful read also sets drvalid = 1 and updates drdata. Timeout sets derr = 1, leaves drdata unchanged, drvalid = 0. Then -> IDLE.
- svalid/srdata are ignored in IDLE, ADDR, WDATA, DONE.
- Latency (accept edge = cycle 0):
  - write: mvalid cycles 1..A+D, dack cycle A+D+1, dready cycle A+D+2.
  - read: mvalid cycles 1..A; if the last data bit arrives at cycle k, dack/drvalid at k+1 and dready at k+2.
- Back-to-back: dvalid held high is accepted again on the first dready cycle.

Decomposition:
- Shared package bus_pkg holds:
  - MODE_READ = 0, MODE_WRITE = 1
  - state enum/localparams for master_port states
  - bit-order constant LSB_FIRST
  - timeout counter width derived as $clog2(TIMEOUT+1)
- One natural sub-module: master_rx_shifter. It is a SIPO with bit counter and done flag, fed by srdata/svalid and cleared on transaction start; it can be reused by slave_port.

Test Plan:
- Write daddr = 0x5A3, dwdata = 0xC7 -> mvalid high cycles 1..20, mmode = 1, mwdata = 1,1,0,0,0,1,0,1,1,0,1,0 then 1,1,1,0,0,0,1,1; dack = 1, derr = 0 at cycle 21; dready = 1 at cycle 22.
- Read daddr = 0x0FF, slave model starts svalid 3 cycles after the last addr bit with 0x3C -> mmode = 0 during addr; drvalid = dack = 1, drdata = 0x3C, derr = 0 one cycle after the 8th bit.
- Read with no slave response -> after 64 idle cycles dack = 1, derr = 1, drvalid = 0, drdata stays 0x3C.
- Read returning 0xA5 with a 2-cycle svalid gap after bit 3, plus svalid pulses injected during ADDR -> the pulses are ignored; drdata = 0xA5, derr = 0.
- dvalid held high across two write requests; rstn asserted in the 5th WDATA cycle of the second -> first completes with dack; after reset, mvalid = 0 next cycle, no dack, dready = 1, and a new read completes normally.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: shared constants, state type and width helper for the serial bus ports
package bus_pkg;
  localparam logic MODE_READ = 1'b0;
  localparam logic MODE_WRITE = 1'b1;
  localparam bit LSB_FIRST = 1'b1;
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RWAIT, RDATA, DONE} mp_state_t;
  function automatic int tmo_width(input int t);
    return $clog2(t + 1);
  endfunction
endpackage

// File: rtl/master_rx_shifter.sv
// master_rx_shifter: SIPO deserializer (clk, rst, clr, en/din in; word = value after this bit, done = this bit completes the word)
module master_rx_shifter
  import bus_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] word,
  output logic         done
);
  localparam int BW = $clog2(W + 1);
  logic [BW-1:0] cnt;
  logic [W-1:0] data;
  assign word = LSB_FIRST ? {din, data[W-1:1]} : {data[W-2:0], din};
  assign done = en && cnt == BW'(W - 1);
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
      data <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
      data <= word;
    end
  end
endmodule

// File: rtl/master_port.sv
// master_port: serial bus initiator; device side (dvalid/dmode/daddr/dwdata -> dready/drdata/drvalid/dack/derr), bus side (mwdata/mmode/mvalid out, srdata/svalid in)
module master_port
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  dvalid,
  input  logic                  dmode,
  input  logic [ADDR_WIDTH-1:0] daddr,
  input  logic [DATA_WIDTH-1:0] dwdata,
  output logic                  dready,
  output logic [DATA_WIDTH-1:0] drdata,
  output logic                  drvalid,
  output logic                  dack,
  output logic                  derr,
  output logic                  mwdata,
  output logic                  mmode,
  output logic                  mvalid,
  input  logic                  srdata,
  input  logic                  svalid
);
  localparam int CW = $clog2((ADDR_WIDTH > DATA_WIDTH ? ADDR_WIDTH : DATA_WIDTH) + 1);
  localparam int TW = tmo_width(TIMEOUT);
  localparam int SW = ADDR_WIDTH + DATA_WIDTH;
  mp_state_t state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [TW-1:0] tcnt;
  logic [SW-1:0] sr, sr_nxt;
  logic [DATA_WIDTH-1:0] rx_word;
  logic mode, mode_nxt, accept, rx, rx_en, rx_done, tmo, tx;
  assign dready = state == IDLE;
  assign accept = dready && dvalid;
  assign rx = state == RWAIT || state == RDATA;
  assign rx_en = rx && svalid;
  assign tmo = rx && !svalid && tcnt == TW'(TIMEOUT - 1);
  // address then data sit in one shift register; bit 0 is always the next bit on the wire
  assign sr_nxt = accept ? {dwdata, daddr} : sr >> 1;
  assign mode_nxt = accept ? dmode : mode;
  // registered bus outputs are computed from the state being entered
  assign tx = nxt == ADDR || nxt == WDATA;
  master_rx_shifter #(.W(DATA_WIDTH)) u_rx (
    .clk (clk),
    .rst (rstn),
    .clr (accept),
    .en  (rx_en),
    .din (srdata),
    .word(rx_word),
    .done(rx_done)
  );
  always_comb begin
    nxt = state;
    cnt_nxt = cnt + 1'b1;
    case (state)
      IDLE: begin
        nxt = dvalid ? ADDR : IDLE;
        cnt_nxt = '0;
      end
      ADDR: if (cnt == CW'(ADDR_WIDTH - 1)) begin
        nxt = mode == MODE_WRITE ? WDATA : RWAIT;
        cnt_nxt = '0;
      end
      WDATA: nxt = cnt == CW'(DATA_WIDTH - 1) ? DONE : WDATA;
      RWAIT, RDATA: nxt = ((rx_en && rx_done) || tmo) ? DONE : (rx_en ? RDATA : state);
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rstn) begin
      state <= IDLE;
      cnt <= '0;
      tcnt <= '0;
      sr <= '0;
      mode <= MODE_READ;
      mvalid <= 1'b0;
      mwdata <= 1'b0;
      mmode <= 1'b0;
      dack <= 1'b0;
      derr <= 1'b0;
      drvalid <= 1'b0;
      drdata <= '0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      // held at zero through ADDR so RWAIT is always entered with a clear count
      tcnt <= (state == ADDR || rx_en) ? '0 : (rx ? tcnt + 1'b1 : tcnt);
      sr <= sr_nxt;
      mode <= mode_nxt;
      mvalid <= tx;
      mwdata <= tx & sr_nxt[0];
      mmode <= tx & mode_nxt;
      dack <= nxt == DONE;
      derr <= tmo;
      drvalid <= rx_en && rx_done;
      drdata <= (rx_en && rx_done) ? rx_word : drdata;
    end
  end
endmodule
